// File: rtl/round_dealer.sv
// Round sequencer for the two-player bell game: deals two cards per round from a
// free-running LFSR, runs the decaying bonus count and arbitrates the first bell press.
module round_dealer #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [7:0]  COUNT_INIT  = 8'd100,
  parameter logic [15:0] TICK_DIV    = 16'd50000,
  parameter logic [7:0]  ROUND_TICKS = 8'd120,
  parameter logic [7:0]  HOLD_CYCLES = 8'd4,
  parameter logic [7:0]  MAX_ROUNDS  = 8'd20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] keypad_in,
  output logic [1:0] c1,
  output logic [1:0] c2,
  output logic [2:0] n1,
  output logic [2:0] n2,
  output logic       card_valid,
  output logic [7:0] count,
  output logic [1:0] who,
  output logic [7:0] round_no,
  output logic       game_over
);

  localparam logic [3:0] KEY_A = 4'b0111;
  localparam logic [3:0] KEY_B = 4'b1001;

  typedef enum logic [2:0] {S_IDLE, S_DEAL, S_WAIT, S_HOLD, S_DONE} state_t;

  state_t      state_q;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [3:0]  key_prev_q;
  logic [15:0] div_q;
  logic [7:0]  tick_q;
  logic [7:0]  hold_q;
  logic [1:0]  c1_q, c2_q, who_q;
  logic [2:0]  n1_q, n2_q;
  logic [7:0]  count_q, round_no_q;
  logic        card_valid_q, game_over_q;

  logic key_is_bell_s, prev_is_bell_s, press_s, last_round_s, tick_due_s;

  // Folds a 3-bit field 0..7 onto card numbers 1..5.
  function automatic logic [2:0] card_num(input logic [2:0] f);
    if (f <= 3'd4) begin
      return f + 3'd1;
    end else begin
      return f - 3'd4;
    end
  endfunction

  assign lfsr_d         = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign key_is_bell_s  = (keypad_in == KEY_A) || (keypad_in == KEY_B);
  assign prev_is_bell_s = (key_prev_q == KEY_A) || (key_prev_q == KEY_B);
  // A bell that was already down on the previous cycle never counts as a new press.
  assign press_s        = (state_q == S_WAIT) && key_is_bell_s && !prev_is_bell_s;
  assign last_round_s   = (round_no_q == MAX_ROUNDS);
  assign tick_due_s     = (div_q == (TICK_DIV - 16'd1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      key_prev_q   <= 4'b0000;
      div_q        <= 16'd0;
      tick_q       <= 8'd0;
      hold_q       <= 8'd0;
      c1_q         <= 2'd0;
      c2_q         <= 2'd0;
      n1_q         <= 3'd0;
      n2_q         <= 3'd0;
      count_q      <= 8'd0;
      who_q        <= 2'b00;
      round_no_q   <= 8'd0;
      card_valid_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      key_prev_q <= keypad_in;
      who_q      <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_DEAL;
          end
        end
        S_DEAL: begin
          c1_q         <= lfsr_q[1:0];
          c2_q         <= lfsr_q[9:8];
          n1_q         <= card_num(lfsr_q[4:2]);
          n2_q         <= card_num(lfsr_q[12:10]);
          count_q      <= COUNT_INIT;
          div_q        <= 16'd0;
          tick_q       <= 8'd0;
          round_no_q   <= round_no_q + 8'd1;
          card_valid_q <= 1'b1;
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          // Press beats a coincident timeout or tick, freezing count at its press-time value.
          if (press_s) begin
            who_q   <= (keypad_in == KEY_A) ? 2'b01 : 2'b10;
            hold_q  <= 8'd0;
            state_q <= S_HOLD;
          end else if (tick_q == ROUND_TICKS) begin
            card_valid_q <= 1'b0;
            game_over_q  <= last_round_s;
            state_q      <= last_round_s ? S_DONE : S_DEAL;
          end else if (tick_due_s) begin
            div_q   <= 16'd0;
            tick_q  <= tick_q + 8'd1;
            count_q <= (count_q > 8'd1) ? (count_q - 8'd1) : 8'd1;
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        S_HOLD: begin
          if (hold_q == (HOLD_CYCLES - 8'd1)) begin
            card_valid_q <= 1'b0;
            game_over_q  <= last_round_s;
            state_q      <= last_round_s ? S_DONE : S_DEAL;
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign c1         = c1_q;
  assign c2         = c2_q;
  assign n1         = n1_q;
  assign n2         = n2_q;
  assign card_valid = card_valid_q;
  assign count      = count_q;
  assign who        = who_q;
  assign round_no   = round_no_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_round_dealer.sv
// Self-checking bench for round_dealer: directed scenarios plus a randomized game run,
// all checked against a round-level behavioural model.
module tb_round_dealer;

  localparam int TD = 4;
  localparam int CI = 10;
  localparam int RT = 12;
  localparam int HC = 3;
  localparam int MR = 3;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [3:0] KA = 4'b0111;
  localparam logic [3:0] KB = 4'b1001;

  localparam int P_IDLE = 0;
  localparam int P_DEAL = 1;
  localparam int P_WAIT = 2;
  localparam int P_HOLD = 3;
  localparam int P_DONE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] keypad_in = 4'd0;
  logic [1:0] c1, c2, who;
  logic [2:0] n1, n2;
  logic       card_valid, game_over;
  logic [7:0] count, round_no;
  logic [29:0] act_s;

  int total = 0;
  int bad = 0;

  // Model state
  int          m_phase = P_IDLE;
  logic [15:0] m_lfsr = SEED;
  logic [1:0]  m_c1 = 2'd0, m_c2 = 2'd0, m_who = 2'd0;
  logic [2:0]  m_n1 = 3'd0, m_n2 = 3'd0;
  int          m_round = 0, m_wait = 0, m_hold = 0, m_count = 0;
  logic [3:0]  m_prev = 4'd0;

  round_dealer #(
    .LFSR_SEED(SEED), .COUNT_INIT(8'd10), .TICK_DIV(16'd4),
    .ROUND_TICKS(8'd12), .HOLD_CYCLES(8'd3), .MAX_ROUNDS(8'd3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .keypad_in(keypad_in),
    .c1(c1), .c2(c2), .n1(n1), .n2(n2), .card_valid(card_valid),
    .count(count), .who(who), .round_no(round_no), .game_over(game_over)
  );

  always #5 clk = ~clk;

  assign act_s = {c1, c2, n1, n2, card_valid, count, who, round_no, game_over};

  function automatic logic is_bell(input logic [3:0] k);
    return (k == KA) || (k == KB);
  endfunction

  function automatic logic [29:0] exp_vec();
    logic cv, go;
    cv = (m_phase == P_WAIT) || (m_phase == P_HOLD);
    go = (m_phase == P_DONE);
    return {m_c1, m_c2, m_n1, m_n2, cv, 8'(m_count), m_who, 8'(m_round), go};
  endfunction

  function automatic int next_after_round();
    return (m_round == MR) ? P_DONE : P_DEAL;
  endfunction

  // Round-level model: count derives from cycles spent waiting, not from a tick register.
  task automatic model_edge(input logic r, input logic s, input logic [3:0] k);
    int f1, f2;
    if (!r) begin
      m_phase = P_IDLE; m_lfsr = SEED; m_c1 = 2'd0; m_c2 = 2'd0; m_n1 = 3'd0; m_n2 = 3'd0;
      m_who = 2'd0; m_round = 0; m_wait = 0; m_hold = 0; m_count = 0; m_prev = 4'd0;
    end else begin
      m_who = 2'd0;
      case (m_phase)
        P_IDLE: if (s) m_phase = P_DEAL;
        P_DEAL: begin
          f1 = int'(m_lfsr[4:2]);
          f2 = int'(m_lfsr[12:10]);
          m_c1 = m_lfsr[1:0];
          m_c2 = m_lfsr[9:8];
          m_n1 = 3'((f1 % 5) + 1);
          m_n2 = 3'((f2 % 5) + 1);
          m_count = CI; m_wait = 0; m_round++; m_phase = P_WAIT;
        end
        P_WAIT: begin
          if (is_bell(k) && !is_bell(m_prev)) begin
            m_who = (k == KA) ? 2'b01 : 2'b10;
            m_hold = HC;
            m_phase = P_HOLD;
          end else if (m_wait == RT * TD) begin
            m_phase = next_after_round();
          end else begin
            m_wait++;
            m_count = (CI - m_wait / TD > 1) ? (CI - m_wait / TD) : 1;
          end
        end
        P_HOLD: begin
          m_hold--;
          if (m_hold == 0) m_phase = next_after_round();
        end
        default: ;
      endcase
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_prev = k;
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic [3:0] k);
    rst = r; start = s; keypad_in = k;
    @(posedge clk);
    model_edge(r, s, k);
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, KA);
    total++;
    if (act_s !== 30'd0) begin bad++; $display("FAIL reset_zero: got %h want %h", act_s, 30'd0); end
    cyc(1'b1, 1'b0, 4'd0);
    total++;
    if (act_s !== exp_vec()) begin bad++; $display("FAIL reset_idle: got %h want %h", act_s, exp_vec()); end
  endtask

  task automatic test_deal();
    cyc(1'b1, 1'b1, 4'd0);
    total++;
    if (card_valid !== 1'b0 || round_no !== 8'd0) begin
      bad++; $display("FAIL pre_deal: got cv=%b rn=%0d want cv=0 rn=0", card_valid, round_no);
    end
    cyc(1'b1, 1'b0, 4'd0);
    total++;
    if (round_no !== 8'd1 || count !== 8'd10 || card_valid !== 1'b1) begin
      bad++; $display("FAIL first_deal: got rn=%0d cnt=%0d cv=%b want 1 10 1", round_no, count, card_valid);
    end
    total++;
    if (n1 < 3'd1 || n1 > 3'd5 || n2 < 3'd1 || n2 > 3'd5) begin
      bad++; $display("FAIL card_range: got n1=%0d n2=%0d want 1..5", n1, n2);
    end
    total++;
    if (act_s !== exp_vec()) begin bad++; $display("FAIL deal_cards: got %h want %h", act_s, exp_vec()); end
  endtask

  task automatic test_timeout();
    logic [3:0] k;
    int n;
    for (int i = 0; i < 8; i++) begin
      k = 4'($urandom);
      if (is_bell(k)) k = 4'd0;
      cyc(1'b1, 1'b0, k);
    end
    total++;
    if (count !== 8'd8) begin bad++; $display("FAIL count_decay: got %0d want 8", count); end
    total++;
    if (act_s !== exp_vec()) begin bad++; $display("FAIL wait_state: got %h want %h", act_s, exp_vec()); end
    n = 0;
    while (round_no !== 8'd2 && n < 80) begin
      cyc(1'b1, 1'b0, 4'd0);
      n++;
      total++;
      if (who !== 2'b00) begin bad++; $display("FAIL timeout_who: got %b want 00", who); end
    end
    total++;
    if (round_no !== 8'd2 || count !== 8'd10 || card_valid !== 1'b1) begin
      bad++; $display("FAIL timeout_redeal: got rn=%0d cnt=%0d cv=%b want 2 10 1", round_no, count, card_valid);
    end
    total++;
    if (act_s !== exp_vec()) begin bad++; $display("FAIL redeal_cards: got %h want %h", act_s, exp_vec()); end
  endtask

  task automatic test_press();
    logic [9:0] cards;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, KA);
    cards = {c1, c2, n1, n2};
    total++;
    if (who !== 2'b01 || count !== 8'd9 || card_valid !== 1'b1) begin
      bad++; $display("FAIL press_a: got who=%b cnt=%0d cv=%b want 01 9 1", who, count, card_valid);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, (i == 0) ? 4'd0 : KB);
      total++;
      if (who !== 2'b00 || count !== 8'd9 || {c1, c2, n1, n2} !== cards || card_valid !== 1'b1) begin
        bad++; $display("FAIL hold_frozen: got who=%b cnt=%0d cards=%h want 00 9 %h", who, count, {c1, c2, n1, n2}, cards);
      end
    end
  endtask

  task automatic test_held_key();
    int n;
    cyc(1'b1, 1'b0, KB);
    total++;
    if (who !== 2'b00 || card_valid !== 1'b0 || count !== 8'd9) begin
      bad++; $display("FAIL hold_exit: got who=%b cv=%b cnt=%0d want 00 0 9", who, card_valid, count);
    end
    cyc(1'b1, 1'b0, KB);
    total++;
    if (round_no !== 8'd3 || act_s !== exp_vec()) begin
      bad++; $display("FAIL third_deal: got %h want %h", act_s, exp_vec());
    end
    n = $urandom_range(3, 10);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, KB);
      total++;
      if (who !== 2'b00) begin bad++; $display("FAIL held_key: got %b want 00", who); end
    end
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, KB);
    total++;
    if (who !== 2'b10) begin bad++; $display("FAIL press_b: got %b want 10", who); end
    for (int i = 0; i < HC; i++) cyc(1'b1, 1'b0, (i == 1) ? KA : 4'd0);
    total++;
    if (game_over !== 1'b1 || card_valid !== 1'b0 || who !== 2'b00) begin
      bad++; $display("FAIL game_end: got go=%b cv=%b who=%b want 1 0 00", game_over, card_valid, who);
    end
  endtask

  task automatic test_done();
    logic [9:0] cards;
    cards = {c1, c2, n1, n2};
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, (i % 2 == 0) ? (($urandom_range(0, 1) == 0) ? KA : KB) : 4'd0);
      total++;
      if (who !== 2'b00 || game_over !== 1'b1 || {c1, c2, n1, n2} !== cards || act_s !== exp_vec()) begin
        bad++; $display("FAIL done_stable: got %h want %h", act_s, exp_vec());
      end
    end
    cyc(1'b0, 1'b0, 4'd0);
    total++;
    if (act_s !== 30'd0) begin bad++; $display("FAIL done_reset: got %h want 0", act_s); end
    cyc(1'b1, 1'b0, 4'd0);
    total++;
    if (act_s !== 30'd0) begin bad++; $display("FAIL done_idle: got %h want 0", act_s); end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b1, 4'd0);
    cyc(1'b1, 1'b0, 4'd0);
    for (int i = 0; i < int'($urandom_range(1, 6)); i++) cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, KA);
    total++;
    if (act_s !== 30'd0 || who !== 2'b00) begin bad++; $display("FAIL mid_reset: got %h want 0", act_s); end
    cyc(1'b1, 1'b0, 4'd0);
    total++;
    if (act_s !== 30'd0) begin bad++; $display("FAIL mid_reset_idle: got %h want 0", act_s); end
  endtask

  task automatic test_random();
    logic [3:0] k;
    logic r, s;
    int sel;
    k = 4'd0;
    cyc(1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 6) k = 4'd0;
      else if (sel == 7) k = KA;
      else if (sel == 8) k = KB;
      else if (sel == 9) k = 4'($urandom);
      r = ($urandom_range(0, 149) != 0);
      s = ($urandom_range(0, 1) == 1);
      cyc(r, s, k);
      total++;
      if (act_s !== exp_vec()) begin
        bad++; $display("FAIL random_cycle %0d: got %h want %h", i, act_s, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_deal();
    test_timeout();
    test_press();
    test_held_key();
    test_done();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
